// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: turns 10-bit SPI command words (2-bit opcode + 8-bit payload)
// into address-latch / write / read operations on a local single-port
// register file, and shares that memory with a host port. SPI has strict
// priority; at most one memory access happens per cycle.
module spi_ram_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic                 host_gnt,
    output logic [7:0]           host_rdata,
    output logic                 host_rvalid,
    output logic                 cmd_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SPI_ACC  = 2'b01,
        ST_HOST_ACC = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WRITE   = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_READ    = 2'b11
    } op_e;

    state_e               state_q, state_d;
    logic                 rx_valid_q;
    logic [9:0]           cmd_q;
    logic                 spi_pend_q;
    logic                 cmd_ovf_q;
    logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q;
    logic [7:0]           tx_data_q;
    logic                 tx_valid_q;
    logic                 host_gnt_q, host_we_q, host_rvalid_q;
    logic [ADDR_SIZE-1:0] host_addr_q;
    logic [7:0]           host_wdata_q, host_rdata_q;
    logic [7:0]           mem_q [MEM_DEPTH];

    logic                 capture, grant, spi_exec, host_exec;
    op_e                  op;
    logic [7:0]           payload;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_waddr, mem_raddr;
    logic [7:0]           mem_wdata, mem_rdata;

    // A rising edge of the level-style rx_valid marks one new SPI word.
    assign capture = rx_valid & ~rx_valid_q;
    assign op      = op_e'(cmd_q[9:8]);
    assign payload = cmd_q[7:0];

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign host_gnt    = host_gnt_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign cmd_ovf     = cmd_ovf_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and arbitration: a pending SPI word always beats the host.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = ST_IDLE;
        grant     = 1'b0;
        spi_exec  = 1'b0;
        host_exec = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (spi_pend_q) begin
                    state_d = ST_SPI_ACC;
                end else if (host_req) begin
                    state_d = ST_HOST_ACC;
                    grant   = 1'b1;
                end
            end
            ST_SPI_ACC:  spi_exec  = 1'b1;
            ST_HOST_ACC: host_exec = 1'b1;
            default:     state_d   = ST_IDLE;
        endcase
    end

    // Single memory port: steer address/data from whichever side owns this cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = host_addr_q;
        mem_wdata = host_wdata_q;
        mem_raddr = host_addr_q;
        if (spi_exec) begin
            mem_we    = (op == OP_WRITE);
            mem_waddr = wr_addr_q;
            mem_wdata = payload;
            mem_raddr = rd_addr_q;
        end else if (host_exec) begin
            mem_we = host_we_q;
        end
    end

    assign mem_rdata = mem_q[mem_raddr];

    // Register file storage.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; clearing it would cost a reset net per bit and software never relies on it.
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    // SPI word capture, pending flag and sticky overflow. A capture coinciding
    // with the SPI_ACC clear wins, so the newer word stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_q <= 1'b1;
            cmd_q      <= '0;
            spi_pend_q <= 1'b0;
            cmd_ovf_q  <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            if (capture) begin
                cmd_q      <= rx_data;
                spi_pend_q <= 1'b1;
                if (spi_pend_q && state_q != ST_SPI_ACC) cmd_ovf_q <= 1'b1;
            end else if (spi_exec) begin
                spi_pend_q <= 1'b0;
            end
        end
    end

    // SPI command execution: address latches and the read byte returned to MISO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            if (spi_exec && op == OP_WR_ADDR) wr_addr_q <= payload[ADDR_SIZE-1:0];
            if (spi_exec && op == OP_RD_ADDR) rd_addr_q <= payload[ADDR_SIZE-1:0];
            if (spi_exec && op == OP_READ)    tx_data_q <= mem_rdata;
            if (capture)                      tx_valid_q <= 1'b0;
            else if (spi_exec && op == OP_READ) tx_valid_q <= 1'b1;
        end
    end

    // Host handshake: latch the request on grant, return read data one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_gnt_q    <= 1'b0;
            host_we_q     <= 1'b0;
            host_addr_q   <= '0;
            host_wdata_q  <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            host_gnt_q    <= grant;
            host_rvalid_q <= host_exec & ~host_we_q;
            if (grant) begin
                host_we_q    <= host_we;
                host_addr_q  <= host_addr;
                host_wdata_q <= host_wdata;
            end
            if (host_exec && !host_we_q) host_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Command sequencer and memory arbiter between the SPI slave datapath and an on-block single-port register file. It decodes the 10-bit words the SPI slave delivers on `rx_data`/`rx_valid` (2-bit opcode plus 8-bit payload) into address-latch, write and read operations. It returns read bytes on `tx_data`/`tx_valid` for the slave to shift out on MISO. A local host port shares the same memory, with fixed priority given to SPI.

## Interface
- `ADDR_SIZE`, default 8: memory address width (1..8); uses payload bits `[ADDR_SIZE-1:0]`.
- `MEM_DEPTH`, default 256: number of 8-bit words; must equal 2**ADDR_SIZE.

One clock; reset is asynchronous and active-high.

- `clk`  in  1  block clock, shared with the SPI slave.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  10  SPI word. [9:8] is the opcode, [7:0] is the payload.
- `rx_valid`  in  1  SPI word valid. Level signal that may stay high for many cycles.
- `tx_data`  out  8  read byte for the SPI slave.
- `tx_valid`  out  1  `tx_data` valid.
- `host_req`  in  1  host access request. Held high until `host_gnt`.
- `host_we`  in  1  1 = write, 0 = read. Stable while `host_req` is high.
- `host_addr`  in  ADDR_SIZE  host address.
- `host_wdata`  in  8  host write data.
- `host_gnt`  out  1  one-cycle pulse: host request accepted and executed.
- `host_rdata`  out  8  host read data.
- `host_rvalid`  out  1  one-cycle pulse: `host_rdata` valid.
- `cmd_ovf`  out  1  sticky flag: an SPI word arrived while the previous one was still pending.

## Operation
- **SPI capture:** register `rx_valid_d`, reset value 1.
  - A capture event is `rx_valid & ~rx_valid_d` at a clock edge.
  - On a capture: `cmd_q <= rx_data`, `spi_pend <= 1`, `tx_valid <= 0`.
  - A level held high for N cycles yields exactly one capture.
  - Because `rx_valid_d` resets to 1, a `rx_valid` already high at reset release does not capture.
- **Opcodes** (executed in SPI_ACC):
  - 00: `wr_addr <= payload`.
  - 01: `mem[wr_addr] <= payload`.
  - 10: `rd_addr <= payload`.
  - 11: `tx_data <= mem[rd_addr]`, `tx_valid <= 1`. The payload is ignored.
- **tx hold:** `tx_data`/`tx_valid` hold until the next capture event (which clears `tx_valid`) or reset.
- **FSM** states, one per cycle:
  - IDLE: if `spi_pend`, go to SPI_ACC. Otherwise, if `host_req`, go to HOST_ACC, pulse `host_gnt`, and latch `host_we`/`host_addr`/`host_wdata`.
  - SPI_ACC: execute `cmd_q`, clear `spi_pend`, go to IDLE.
  - HOST_ACC: if write, `mem[addr] <= wdata`. If read, `host_rdata <= mem[addr]` and pulse `host_rvalid`. Go to IDLE.
  - Undefined encodings go to IDLE.
- **Arbitration:** SPI has strict priority. At most one memory access per cycle.
- **Simultaneous capture and clear:** if a capture coincides with the SPI_ACC clear, the capture wins (`spi_pend` stays 1, new `cmd_q`).
- **Overflow:** a capture while `spi_pend` = 1 and not in SPI_ACC overwrites `cmd_q` and sets `cmd_ovf`. `cmd_ovf` clears only on reset.
- **Reset values:**
  - Outputs: `tx_data` 0, `tx_valid` 0, `host_gnt` 0, `host_rdata` 0, `host_rvalid` 0, `cmd_ovf` 0.
  - Internal: `wr_addr` 0, `rd_addr` 0, `spi_pend` 0, FSM in IDLE.
  - Memory contents are not reset.

## Timing
- **SPI latency:** capture edge E0, SPI_ACC entered at E1, execute at E2. `tx_valid` is high after E2, i.e. 2 cycles after the edge that sampled `rx_valid` rising.
- **SPI worst case:** if a host access is in HOST_ACC at E0, add 1 cycle. Worst case is 3 cycles.
- **Host handshake:**
  - `host_gnt` is high for the cycle after the granting edge.
  - The host may drop or change `host_req` after seeing `host_gnt`. If `host_req` is still high in the next IDLE, a new access is granted.
  - `host_rvalid` pulses 1 cycle after `host_gnt`.
  - Maximum host throughput is 1 access per 2 cycles when SPI is idle.
- **Host wait:** while `spi_pend` is set, the host waits. SPI words are at least 11 cycles apart, so host wait is bounded at 2 cycles.
- **Reset mid-operation:** an asynchronous assert immediately forces all reset values. A pending SPI command or a granted but not-yet-completed host read is discarded; no `host_rvalid` follows.

## Test plan
- **SPI write/read:** send SPI words 0x0_3C (00), 0x1_A5 (01), 0x2_3C (10), 0x3_00 (11), each with `rx_valid` held 5 cycles. Expect `tx_data` = 0xA5 and `tx_valid` = 1 exactly 2 cycles after the last rise; `tx_valid` clears on the next capture.
- **Level-held rx_valid:** hold `rx_valid` high for 20 cycles with opcode 01. Expect exactly one memory write, and `cmd_ovf` stays 0.
- **Host write, SPI read:** host writes 0x77 to 0x10 (`host_gnt` pulse 1 cycle after `host_req`). Then SPI opcode 10 with payload 0x10 followed by opcode 11. Expect `tx_data` = 0x77.
- **Contention:** assert `host_req` (read of 0x10) on the same edge an SPI capture occurs. Expect SPI_ACC first, `host_gnt` delayed by 2 cycles, then `host_rdata` = 0x77 with a `host_rvalid` pulse.
- **Reset mid-operation:** assert `rst` in the cycle after capture of opcode 01 with payload 0x55. Expect all outputs at reset values, memory at `wr_addr` unchanged. Release `rst` with `rx_valid` high: no capture occurs.
- **Overflow:** force two `rx_valid` rises 1 cycle apart while `host_req` holds HOST_ACC. Expect `cmd_ovf` = 1 and only the second command executed.
